// File: rtl/stream_prefix_sum32.sv
// Stream endpoint that keeps a running modulo-2^DATA_W sum of accepted words
// and queues every updated sum in an output FIFO for the output stream.
module stream_prefix_sum32 #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              si_valid,
  output logic              si_ready,
  input  logic [DATA_W-1:0] si_data,
  output logic              so_valid,
  input  logic              so_ready,
  output logic [DATA_W-1:0] so_data,
  input  logic              clear,
  output logic [31:0]       word_count,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] storage [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum_new;
  logic              armed;
  logic              push;
  logic              pop;

  // armed holds si_ready low until the first edge after reset release
  assign si_ready = armed && (fifo_level != FULL_LVL);
  assign so_valid = (fifo_level != '0);
  assign so_data  = storage[rd_ptr];
  assign push     = si_valid && si_ready;
  assign pop      = so_valid && so_ready;
  assign sum_new  = (clear ? '0 : acc) + si_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      acc        <= '0;
      word_count <= '0;
    end else begin
      armed <= 1'b1;
      if (push) begin
        acc        <= sum_new;
        word_count <= (clear ? 32'd0 : word_count) + 32'd1;
      end else if (clear) begin
        acc        <= '0;
        word_count <= '0;
      end
    end
  end

  // Sum storage needs no reset: entries are only read while fifo_level says valid
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= sum_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_prefix_sum32.sv
// Directed self-checking bench for stream_prefix_sum32: loopback, backpressure,
// wrap, clear, simultaneous push/pop and asynchronous reset mid-stream.
module tb_stream_prefix_sum32;

  logic        clk;
  logic        rst_n;
  logic        si_valid;
  logic        si_ready;
  logic [31:0] si_data;
  logic        so_valid;
  logic        so_ready;
  logic [31:0] so_data;
  logic        clear;
  logic [31:0] word_count;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  stream_prefix_sum32 #(.DATA_W(32), .FIFO_DEPTH(16), .LVL_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .si_valid   (si_valid),
    .si_ready   (si_ready),
    .si_data    (si_data),
    .so_valid   (so_valid),
    .so_ready   (so_ready),
    .so_data    (so_data),
    .clear      (clear),
    .word_count (word_count),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are set at the falling edge; outputs are sampled there too
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic c, input logic r);
    si_valid = v;
    si_data  = d;
    clear    = c;
    so_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pushWord(input logic [31:0] d, input logic c);
    checkOutput("push_ready", 32'(si_ready), 32'd1);
    applyStimulus(1'b1, d, c, 1'b0);
    si_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [31:0] exp);
    checkOutput({tag, "_valid"}, 32'(so_valid), 32'd1);
    checkOutput(tag, so_data, exp);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    so_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int out_idx;
    int accepted;
    int exp_val;
    logic [31:0] last_sum;
    logic pushed;

    rst_n    = 1'b0;
    si_valid = 1'b0;
    si_data  = '0;
    so_ready = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_so_valid", 32'(so_valid), 32'd0);
    checkOutput("rst_si_ready", 32'(si_ready), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_count", word_count, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_si_ready", 32'(si_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("arm_si_ready", 32'(si_ready), 32'd1);

    // Loopback with so_ready held high
    $display("[TB] loopback 0..3071");
    out_idx  = 0;
    last_sum = '0;
    for (int i = 0; i < 3072; i++) begin
      if (so_valid) begin
        checkOutput("loop_sum", so_data, 32'(out_idx * (out_idx + 1) / 2));
        last_sum = so_data;
        out_idx++;
      end
      checkOutput("loop_ready", 32'(si_ready), 32'd1);
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b1);
    end
    si_valid = 1'b0;
    for (int g = 0; g < 8 && so_valid; g++) begin
      checkOutput("loop_sum", so_data, 32'(out_idx * (out_idx + 1) / 2));
      last_sum = so_data;
      out_idx++;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    end
    so_ready = 1'b0;
    checkOutput("loop_n_out", 32'(out_idx), 32'd3072);
    checkOutput("loop_last", last_sum, 32'd4717056);
    checkOutput("loop_count", word_count, 32'd3072);
    checkOutput("loop_level", 32'(fifo_level), 32'd0);

    // Clear without push
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    clear = 1'b0;
    checkOutput("clr_count", word_count, 32'd0);
    checkOutput("clr_level", 32'(fifo_level), 32'd0);

    // Backpressure: 17 words of 1 offered, FIFO holds 16
    $display("[TB] backpressure");
    accepted = 0;
    for (int c = 0; c < 17; c++) begin
      if (si_ready) accepted++;
      applyStimulus(1'b1, 32'd1, 1'b0, 1'b0);
    end
    checkOutput("bp_accepted", 32'(accepted), 32'd16);
    checkOutput("bp_si_ready", 32'(si_ready), 32'd0);
    checkOutput("bp_level", 32'(fifo_level), 32'd16);
    checkOutput("bp_count", word_count, 32'd16);
    exp_val = 1;
    for (int g = 0; g < 60 && exp_val <= 17; g++) begin
      if (so_valid) begin
        checkOutput("bp_sum", so_data, 32'(exp_val));
        exp_val++;
      end
      pushed = si_valid && si_ready;
      applyStimulus(si_valid, 32'd1, 1'b0, 1'b1);
      if (pushed) si_valid = 1'b0;
    end
    so_ready = 1'b0;
    si_valid = 1'b0;
    checkOutput("bp_n_out", 32'(exp_val), 32'd18);
    checkOutput("bp_count17", word_count, 32'd17);
    checkOutput("bp_level_end", 32'(fifo_level), 32'd0);

    // Modulo wrap
    $display("[TB] wrap");
    pushWord(32'hFFFF_FFFF, 1'b1);
    pushWord(32'h0000_0002, 1'b0);
    popCheck("wrap0", 32'hFFFF_FFFF);
    popCheck("wrap1", 32'h0000_0001);

    // Clear coinciding with a push
    $display("[TB] clear with push");
    pushWord(32'd10, 1'b1);
    pushWord(32'd5, 1'b1);
    checkOutput("clrp_count1", word_count, 32'd1);
    pushWord(32'd3, 1'b0);
    checkOutput("clrp_count2", word_count, 32'd2);
    popCheck("clrp_10", 32'd10);
    popCheck("clrp_5", 32'd5);
    popCheck("clrp_8", 32'd8);

    // Simultaneous push and pop at level 3
    $display("[TB] push+pop");
    pushWord(32'd100, 1'b1);
    pushWord(32'd1, 1'b0);
    pushWord(32'd1, 1'b0);
    checkOutput("pp_level3", 32'(fifo_level), 32'd3);
    checkOutput("pp_head", so_data, 32'd100);
    checkOutput("pp_ready", 32'(si_ready), 32'd1);
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b1);
    si_valid = 1'b0;
    so_ready = 1'b0;
    checkOutput("pp_level_same", 32'(fifo_level), 32'd3);
    popCheck("pp_101", 32'd101);
    popCheck("pp_102", 32'd102);
    popCheck("pp_106", 32'd106);
    checkOutput("pp_empty", 32'(fifo_level), 32'd0);

    // Asynchronous reset mid-stream
    $display("[TB] reset mid-stream");
    for (int k = 0; k < 5; k++) pushWord(32'(k + 1), 1'b0);
    checkOutput("mr_level5", 32'(fifo_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_so_valid", 32'(so_valid), 32'd0);
    checkOutput("mr_si_ready", 32'(si_ready), 32'd0);
    checkOutput("mr_level", 32'(fifo_level), 32'd0);
    checkOutput("mr_count", word_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pushWord(32'd7, 1'b0);
    checkOutput("mr_count1", word_count, 32'd1);
    popCheck("mr_sum7", 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
